// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Bytes are pushed with a valid/ready handshake and sent LSB-first with one
// start bit and one stop bit. Frames run back-to-back while the FIFO has data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [7:0]         TxData,
  input  logic               TxValid,
  output logic               TxReady,
  output logic               Tx,
  output logic               TxBusy,
  output logic               TxDone,
  output logic [FIFO_AW:0]   FifoCount
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    count_q;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, bit_end;

  assign full    = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = TxValid && !full;
  assign bit_end = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  assign TxReady   = !full;
  assign Tx        = tx_q;
  assign FifoCount = count_q;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: a pop (registered count only) starts a frame from IDLE or
  // straight out of STOP so consecutive frames have no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_cnt_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath next values: line level, bit/clock counters, shifter, pop.
  always_comb begin
    pop       = 1'b0;
    tx_d      = tx_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    TxBusy    = (state_q != S_IDLE);
    TxDone    = (state_q == S_STOP) && bit_end;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        tx_d      = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            // shift_q[0] is on the line now, so shift_q[1] is the next bit.
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  // Control registers: counters, line level and FIFO pointers/occupancy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data storage: FIFO array and shift register need no reset.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= TxData;
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based frame model compared every cycle,
// a serial decoder on Tx, and literal expectations for directed scenarios.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [7:0]   TxData = 8'h00;
  logic         TxValid = 1'b0;
  logic         TxReady, Tx, TxBusy, TxDone;
  logic [AW:0]  FifoCount;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady), .Tx(Tx), .TxBusy(TxBusy), .TxDone(TxDone),
    .FifoCount(FifoCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   mq[$];          // bytes waiting in the FIFO
  int   push_log[$];    // every byte accepted
  int   frame = -1;     // cycle index within the current frame, -1 when idle
  int   cur = 0;        // byte being sent
  logic do_push;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mq.delete();
      frame = -1;
    end else begin
      do_push = TxValid && (mq.size() < DEPTH);
      if (frame < 0 || frame == FRAME - 1) begin
        if (mq.size() > 0) begin
          cur   = mq.pop_front();
          frame = 0;
        end else begin
          frame = -1;
        end
      end else begin
        frame++;
      end
      if (do_push) begin
        mq.push_back(int'(TxData));
        push_log.push_back(int'(TxData));
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (frame < 0) return 1'b1;
    b = frame / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  always @(negedge Clk) begin
    chk("tx",     Tx,        exp_tx());
    chk("busy",   TxBusy,    frame >= 0);
    chk("done",   TxDone,    frame == FRAME - 1);
    chk("count",  FifoCount, mq.size());
    chk("ready",  TxReady,   mq.size() < DEPTH);
  end

  // ---------------- serial decoder and done monitor ----------------
  int         cyc = 0;
  int         done_t[$];
  int         rx_q[$];
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) if (TxDone === 1'b1) done_t.push_back(cyc);

  always @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (Tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_sh[rx_cnt / CPB - 1] = Tx;
        if (rx_cnt / CPB == 9) begin
          chk("rx_stop", Tx, 1);
          rx_q.push_back(int'(rx_sh));
          rx_act = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_one(input logic [7:0] d);
    TxData  = d;
    TxValid = 1'b1;
    @(posedge Clk); #1;
    TxValid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((TxBusy !== 1'b0 || FifoCount !== '0) && n < bound) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("drain_busy_count", {TxBusy, FifoCount}, 0);
  endtask

  // Called at frame cycle 0; lit[i] is the i-th bit on the line.
  task automatic sample_frame(input logic [9:0] lit);
    repeat (CPB / 2) @(posedge Clk);
    #1;
    for (int b = 0; b < 10; b++) begin
      chk("frame_bit", Tx, lit[b]);
      if (b < 9) begin
        repeat (CPB) @(posedge Clk);
        #1;
      end
    end
  endtask

  task automatic chk_rx(input int idx, input logic [7:0] e);
    chk("rx_byte", (idx < rx_q.size()) ? rx_q[idx] : 32'hFFFF_FFFF, e);
  endtask

  initial begin
    int base, d0, idx, mx, guard, pb;
    logic rdy;

    // Reset values
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_tx", Tx, 1);
    chk("rst_busy", TxBusy, 0);
    chk("rst_done", TxDone, 0);
    chk("rst_count", FifoCount, 0);
    chk("rst_ready", TxReady, 1);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Idle: nothing pushed for 1000 cycles
    d0 = done_t.size();
    repeat (1000) @(posedge Clk);
    #1;
    chk("idle_dones", done_t.size() - d0, 0);
    chk("idle_tx", Tx, 1);
    chk("idle_ready", TxReady, 1);

    // Single byte 0x61 with latency and exact bit pattern
    base = rx_q.size();
    d0 = done_t.size();
    push_one(8'h61);
    chk("lat_tx_k", Tx, 1);
    chk("lat_cnt_k", FifoCount, 1);
    @(posedge Clk); #1;
    chk("lat_tx_k1", Tx, 0);
    chk("lat_cnt_k1", FifoCount, 0);
    sample_frame(10'b1011000010);
    wait_idle(2 * FRAME);
    chk("single_dones", done_t.size() - d0, 1);
    chk_rx(base, 8'h61);

    // Back-to-back frames
    base = rx_q.size();
    d0 = done_t.size();
    TxValid = 1'b1; TxData = 8'h55; @(posedge Clk); #1;
    TxData = 8'hA3; @(posedge Clk); #1;
    TxData = 8'h00; @(posedge Clk); #1;
    TxValid = 1'b0;
    wait_idle(5 * FRAME);
    chk("b2b_dones", done_t.size() - d0, 3);
    chk("b2b_gap1", done_t[d0+1] - done_t[d0], FRAME);
    chk("b2b_gap2", done_t[d0+2] - done_t[d0+1], FRAME);
    chk_rx(base, 8'h55);
    chk_rx(base + 1, 8'hA3);
    chk_rx(base + 2, 8'h00);

    // FIFO full with TxValid held high
    base = rx_q.size();
    idx = 0; mx = 0; guard = 0;
    TxValid = 1'b1; TxData = 8'h10;
    while (idx < 8 && guard < 20 * FRAME) begin
      rdy = TxReady;
      if (int'(FifoCount) > mx) mx = int'(FifoCount);
      @(posedge Clk); #1;
      guard++;
      if (rdy) begin
        idx++;
        TxData = 8'h10 + 8'(idx);
      end
    end
    TxValid = 1'b0;
    chk("full_pushes", idx, 8);
    chk("full_maxcount", mx, DEPTH);
    wait_idle(10 * FRAME);
    for (int i = 0; i < 8; i++) chk_rx(base + i, 8'h10 + 8'(i));

    // Push on the same edge a STOP completes
    base = rx_q.size();
    TxValid = 1'b1; TxData = 8'h81; @(posedge Clk); #1;
    TxData = 8'h42; @(posedge Clk); #1;
    TxData = 8'h24; @(posedge Clk); #1;
    TxValid = 1'b0;
    chk("pp_count_before", FifoCount, 2);
    guard = 0;
    while (TxDone !== 1'b1 && guard < 2 * FRAME) begin
      @(posedge Clk); #1;
      guard++;
    end
    chk("pp_done_seen", TxDone, 1);
    push_one(8'h3C);
    chk("pp_count_after", FifoCount, 2);
    chk("pp_tx_start", Tx, 0);
    chk("pp_busy", TxBusy, 1);
    wait_idle(6 * FRAME);
    chk_rx(base, 8'h81);
    chk_rx(base + 1, 8'h42);
    chk_rx(base + 2, 8'h24);
    chk_rx(base + 3, 8'h3C);

    // Reset during DATA bit 3 with two bytes queued
    push_one(8'hA5);
    @(posedge Clk); #1;
    push_one(8'h11);
    push_one(8'h22);
    chk("mr_count", FifoCount, 2);
    repeat (4 * CPB + CPB / 2 - 2) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("mr_tx", Tx, 1);
    chk("mr_busy", TxBusy, 0);
    chk("mr_count0", FifoCount, 0);
    chk("mr_ready", TxReady, 1);
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    base = rx_q.size();
    push_one(8'hF0);
    @(posedge Clk); #1;
    sample_frame(10'b1111100000);
    wait_idle(2 * FRAME);
    chk("mr_rx_count", rx_q.size() - base, 1);
    chk_rx(base, 8'hF0);

    // Randomised traffic, sparse then dense
    base = rx_q.size();
    pb = push_log.size();
    for (int i = 0; i < 4000; i++) begin
      TxValid = (i < 2000) ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 9) < 3);
      TxData  = 8'($urandom);
      @(posedge Clk); #1;
    end
    TxValid = 1'b0;
    wait_idle(8 * FRAME);
    chk("rand_nbytes", rx_q.size() - base, push_log.size() - pb);
    for (int i = 0; i < push_log.size() - pb; i++)
      chk_rx(base + i, 8'(push_log[pb + i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
